nv_nvdla_pdp_wdma_dat_fifo_ctrl: RTL and testbench

Valid/ready controller that sequences the PDP WDMA data 3x64 flop-RAM as a 3-entry FIFO. It sits between the PDP write-data producer and the DMA write-request packer. It owns the write/read pointers, the occupancy count, and the RAM `we`/`wa`/`ra` controls. Read data comes back combinationally from the RAM `dout`. With bypass compiled in, an empty FIFO passes input straight through by driving `ra=3`, which makes the RAM mux select `di`.

---
 rtl/nv_nvdla_pdp_wdma_dat_fifo_ctrl.sv | 85 ++++++++
 tb/tb_nv_nvdla_pdp_wdma_dat_fifo_ctrl.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/nv_nvdla_pdp_wdma_dat_fifo_ctrl.sv
// Valid/ready controller sequencing the PDP WDMA 3x64 flop-RAM as a 3-entry FIFO.
// Optional same-cycle pass-through when empty: NV_NVDLA_PDP_WDMA_DAT_FIFO_BYPASS_EN.
module nv_nvdla_pdp_wdma_dat_fifo_ctrl #(
  parameter int unsigned DEPTH = 3,
  parameter int unsigned WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_pvld,
  output logic             wr_prdy,
  input  logic [WIDTH-1:0] wr_pd,
  output logic             rd_pvld,
  input  logic             rd_prdy,
  output logic [WIDTH-1:0] rd_pd,
  output logic             ram_we,
  output logic [1:0]       ram_wa,
  output logic [1:0]       ram_ra,
  output logic [WIDTH-1:0] ram_di,
  input  logic [WIDTH-1:0] ram_dout,
  output logic [1:0]       fifo_count,
  output logic             fifo_idle
);

  localparam logic [1:0] LAST = 2'(DEPTH - 1);
  localparam logic [1:0] FULL = 2'(DEPTH);

  logic [1:0] wr_ptr;
  logic [1:0] rd_ptr;
  logic [1:0] count;
  logic       empty;
  logic       bypass_take;
  logic       push;
  logic       pop;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == LAST) ? 2'd0 : p + 2'd1;
  endfunction

  assign empty   = (count == '0);
  assign wr_prdy = !rst && (count != FULL);

`ifdef NV_NVDLA_PDP_WDMA_DAT_FIFO_BYPASS_EN
  // Empty FIFO hands producer data straight to the consumer via RAM address 3.
  assign bypass_take = empty && wr_pvld && rd_prdy && !rst;
  assign rd_pvld     = !rst && (!empty || wr_pvld);
  assign ram_ra      = empty ? 2'd3 : rd_ptr;
`else
  assign bypass_take = 1'b0;
  assign rd_pvld     = !rst && !empty;
  assign ram_ra      = rd_ptr;
`endif

  assign push       = wr_pvld && wr_prdy && !bypass_take;
  assign pop        = rd_pvld && rd_prdy && !empty;
  assign ram_we     = push;
  assign ram_wa     = wr_ptr;
  assign ram_di     = wr_pd;
  assign rd_pd      = ram_dout;
  assign fifo_count = count;
  assign fifo_idle  = empty && !wr_pvld;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(push && !pop && count == FULL));
      assert (!(pop && !push && empty));
    end
  end

endmodule

// File: tb/tb_nv_nvdla_pdp_wdma_dat_fifo_ctrl.sv
// Directed table-driven bench for the PDP WDMA data FIFO controller, with a 3x64 RAM model.
module tb_nv_nvdla_pdp_wdma_dat_fifo_ctrl;

`ifdef NV_NVDLA_PDP_WDMA_DAT_FIFO_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_pvld;
  logic        wr_prdy;
  logic [63:0] wr_pd;
  logic        rd_pvld;
  logic        rd_prdy;
  logic [63:0] rd_pd;
  logic        ram_we;
  logic [1:0]  ram_wa;
  logic [1:0]  ram_ra;
  logic [63:0] ram_di;
  logic [63:0] ram_dout;
  logic [1:0]  fifo_count;
  logic        fifo_idle;

  logic [63:0] mem [0:2];

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  nv_nvdla_pdp_wdma_dat_fifo_ctrl #(.DEPTH(3), .WIDTH(64)) dut (
    .clk(clk), .rst(rst),
    .wr_pvld(wr_pvld), .wr_prdy(wr_prdy), .wr_pd(wr_pd),
    .rd_pvld(rd_pvld), .rd_prdy(rd_prdy), .rd_pd(rd_pd),
    .ram_we(ram_we), .ram_wa(ram_wa), .ram_ra(ram_ra),
    .ram_di(ram_di), .ram_dout(ram_dout),
    .fifo_count(fifo_count), .fifo_idle(fifo_idle)
  );

  // Flop RAM: address 3 selects di.
  always_ff @(posedge clk) if (ram_we && ram_wa != 2'd3) mem[ram_wa] <= ram_di;
  assign ram_dout = (ram_ra == 2'd3) ? ram_di : mem[ram_ra];

  typedef struct {
    logic        rst, wv, rr;
    logic [63:0] wpd;
    logic        e_wrdy, e_rvld, e_we;
    logic [1:0]  e_wa, e_ra, e_cnt;
    logic        e_idle, chk_pd;
    logic [63:0] e_pd;
  } vec_t;

  vec_t tbl [18];

  function automatic vec_t mk(input logic r, input logic wv, input logic [63:0] wpd,
                              input logic rr, input logic wrdy, input logic rvld,
                              input logic we, input logic [1:0] wa, input logic [1:0] ra,
                              input logic [1:0] cnt, input logic idle, input logic cp,
                              input logic [63:0] pd);
    vec_t v;
    v.rst = r; v.wv = wv; v.wpd = wpd; v.rr = rr;
    v.e_wrdy = wrdy; v.e_rvld = rvld; v.e_we = we; v.e_wa = wa; v.e_ra = ra;
    v.e_cnt = cnt; v.e_idle = idle; v.chk_pd = cp; v.e_pd = pd;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [1:0]  ra_exp;
    logic        rvld_exp;
    logic [63:0] w;

    //              rst wv wpd      rr  wrdy rvld we wa ra cnt idle cp pd
    tbl[0]  = mk(1, 0, 64'h0,    0,  0, 0, 0, 0, 0, 0, 1, 0, 64'h0);
    tbl[1]  = mk(0, 1, 64'h1111, 0,  1, 0, 1, 0, 0, 0, 0, 0, 64'h0);
    tbl[2]  = mk(0, 0, 64'h0,    0,  1, 1, 0, 1, 0, 1, 0, 1, 64'h1111);
    tbl[3]  = mk(0, 1, 64'h2222, 0,  1, 1, 1, 1, 0, 1, 0, 1, 64'h1111);
    tbl[4]  = mk(0, 1, 64'h3333, 0,  1, 1, 1, 2, 0, 2, 0, 1, 64'h1111);
    tbl[5]  = mk(0, 1, 64'h4444, 0,  0, 1, 0, 0, 0, 3, 0, 1, 64'h1111);
    tbl[6]  = mk(0, 1, 64'h4444, 1,  0, 1, 0, 0, 0, 3, 0, 1, 64'h1111);
    tbl[7]  = mk(0, 1, 64'h4444, 1,  1, 1, 1, 0, 1, 2, 0, 1, 64'h2222);
    tbl[8]  = mk(0, 0, 64'h0,    1,  1, 1, 0, 1, 2, 2, 0, 1, 64'h3333);
    tbl[9]  = mk(0, 0, 64'h0,    1,  1, 1, 0, 1, 0, 1, 0, 1, 64'h4444);
    tbl[10] = mk(0, 0, 64'h0,    0,  1, 0, 0, 1, 1, 0, 1, 0, 64'h0);
    tbl[11] = mk(0, 1, 64'h5555, 0,  1, 0, 1, 1, 1, 0, 0, 0, 64'h0);
    tbl[12] = mk(0, 1, 64'h6666, 0,  1, 1, 1, 2, 1, 1, 0, 1, 64'h5555);
    tbl[13] = mk(1, 0, 64'h0,    0,  0, 0, 0, 0, 1, 2, 0, 1, 64'h5555);
    tbl[14] = mk(0, 1, 64'h7777, 0,  1, 0, 1, 0, 0, 0, 0, 0, 64'h0);
    tbl[15] = mk(0, 0, 64'h0,    0,  1, 1, 0, 1, 0, 1, 0, 1, 64'h7777);
    tbl[16] = mk(0, 0, 64'h0,    1,  1, 1, 0, 1, 0, 1, 0, 1, 64'h7777);
    tbl[17] = mk(0, 0, 64'h0,    0,  1, 0, 0, 1, 1, 0, 1, 0, 64'h0);

    rst = 1'b1; wr_pvld = 1'b0; wr_pd = '0; rd_prdy = 1'b0;
    tick(); tick();

    for (int unsigned i = 0; i < 18; i++) begin
      rst = tbl[i].rst; wr_pvld = tbl[i].wv; wr_pd = tbl[i].wpd; rd_prdy = tbl[i].rr;
      #3;
      // Empty-with-valid rows turn into pass-through when bypass is compiled in.
      rvld_exp = tbl[i].e_rvld | (BYP & (tbl[i].e_cnt == 2'd0) & tbl[i].wv & !tbl[i].rst);
      ra_exp   = (BYP && tbl[i].e_cnt == 2'd0) ? 2'd3 : tbl[i].e_ra;
      chk($sformatf("v%0d wr_prdy", i), 64'(wr_prdy), 64'(tbl[i].e_wrdy));
      chk($sformatf("v%0d rd_pvld", i), 64'(rd_pvld), 64'(rvld_exp));
      chk($sformatf("v%0d ram_we", i), 64'(ram_we), 64'(tbl[i].e_we));
      chk($sformatf("v%0d ram_wa", i), 64'(ram_wa), 64'(tbl[i].e_wa));
      chk($sformatf("v%0d ram_ra", i), 64'(ram_ra), 64'(ra_exp));
      chk($sformatf("v%0d count", i), 64'(fifo_count), 64'(tbl[i].e_cnt));
      chk($sformatf("v%0d idle", i), 64'(fifo_idle), 64'(tbl[i].e_idle));
      chk($sformatf("v%0d ram_di", i), ram_di, tbl[i].wpd);
      if (tbl[i].chk_pd) chk($sformatf("v%0d rd_pd", i), rd_pd, tbl[i].e_pd);
      tick();
    end

    // Wrap-around: 7 back-to-back transfers from a fresh reset.
    rst = 1'b1; wr_pvld = 1'b0; rd_prdy = 1'b0;
    tick();
    rst = 1'b0;
    for (int unsigned k = 0; k < 8; k++) begin
      wr_pvld = (k < 7);
      wr_pd   = 64'hA000 + 64'(k);
      rd_prdy = 1'b1;
      #3;
      chk($sformatf("wrap%0d count_le1", k), 64'(fifo_count <= 2'd1), 64'd1);
      if (BYP) begin
        chk($sformatf("wrap%0d we", k), 64'(ram_we), 64'd0);
        chk($sformatf("wrap%0d rd_pvld", k), 64'(rd_pvld), 64'(k < 7));
        if (k < 7) chk($sformatf("wrap%0d rd_pd", k), rd_pd, 64'hA000 + 64'(k));
      end else begin
        if (k < 7) begin
          chk($sformatf("wrap%0d we", k), 64'(ram_we), 64'd1);
          chk($sformatf("wrap%0d wa", k), 64'(ram_wa), 64'(k % 3));
        end
        chk($sformatf("wrap%0d rd_pvld", k), 64'(rd_pvld), 64'(k > 0));
        if (k > 0) chk($sformatf("wrap%0d rd_pd", k), rd_pd, 64'hA000 + 64'(k - 1));
      end
      tick();
    end

    // Empty FIFO with producer and consumer both ready.
    wr_pvld = 1'b1; wr_pd = 64'hABCD; rd_prdy = 1'b1;
    #3;
    w = BYP ? 64'd1 : 64'd0;
    chk("byp rd_pvld", 64'(rd_pvld), w);
    chk("byp we", 64'(ram_we), 64'(!BYP));
    if (BYP) begin
      chk("byp ra", 64'(ram_ra), 64'd3);
      chk("byp rd_pd", rd_pd, 64'hABCD);
    end
    tick();
    wr_pvld = 1'b0; wr_pd = '0;
    #3;
    chk("byp next count", 64'(fifo_count), BYP ? 64'd0 : 64'd1);
    chk("byp next rd_pvld", 64'(rd_pvld), BYP ? 64'd0 : 64'd1);
    if (!BYP) chk("byp next rd_pd", rd_pd, 64'hABCD);
    tick();
    rd_prdy = 1'b0;
    #3;
    chk("final count", 64'(fifo_count), 64'd0);
    chk("final idle", 64'(fifo_idle), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
